// File: rtl/uart_bus_device_pkg.sv
// ----------------------------------------------------------------------------
// uart_bus_device_pkg : register offsets, CON bit positions, shared FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_bus_device_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0000_0000;
  localparam logic [31:0] OFF_RXD = 32'h0000_0004;
  localparam logic [31:0] OFF_CON = 32'h0000_0008;

  localparam int CON_RX_VALID   = 0;
  localparam int CON_TX_FULL    = 1;
  localparam int CON_TX_BUSY    = 2;
  localparam int CON_RX_OVERRUN = 3;
  localparam int CON_RX_IRQ_EN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Width of a counter that must hold 0..div-1.
  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bus_device_rx.sv
// ----------------------------------------------------------------------------
// uart_rx_engine : 2-flop synchronizer plus 8N1 receive FSM, done on stop=1
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_engine
  import uart_bus_device_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       done
);

  localparam int            CW        = cnt_width(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // sync[1] is the synchronized line, sync[2] its previous value for edge detect
  logic [2:0]    sync;
  logic          line;
  logic          line_prev;

  uart_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          done_d;

  assign line      = sync[1];
  assign line_prev = sync[2];
  assign data      = shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync    <= 3'b111;
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      done    <= 1'b0;
    end else begin
      sync    <= {sync[1:0], rxd};
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    done_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line_prev && !line) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = line ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {line, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = line;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_bus_device.sv
// ----------------------------------------------------------------------------
// uart_bus_device : memory-mapped UART with TX FIFO, 8N1 TX/RX and RX interrupt
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_bus_device
  import uart_bus_device_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 9600,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Device_Read,
  input  logic        Device_Write,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam int            DIV      = CLK_FREQ / BAUD;
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = cnt_width(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic sel_txd, sel_rxd, sel_con;
  logic rxd_read, con_write;

  assign sel_txd   = (MemBus_Address == BASE_ADDR + OFF_TXD);
  assign sel_rxd   = (MemBus_Address == BASE_ADDR + OFF_RXD);
  assign sel_con   = (MemBus_Address == BASE_ADDR + OFF_CON);
  assign rxd_read  = Device_Read && sel_rxd;
  assign con_write = Device_Write && sel_con;

  logic unused_wdata;
  assign unused_wdata = ^MemBus_Write_Data[31:8];

  // TX FIFO: one extra pointer bit distinguishes full from empty
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = Device_Write && sel_txd && !fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= MemBus_Write_Data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  uart_state_t   tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]    tx_bit, tx_bit_d;
  logic [7:0]    tx_shift, tx_shift_d;
  logic          txd_d;
  logic          tx_busy;

  assign tx_busy = !fifo_empty || (tx_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      uart_txd <= txd_d;
    end
  end

  // Line level is registered from the next state so the pin never glitches
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    pop        = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr[AW-1:0]];
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_bit_d   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    case (tx_state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  logic [7:0] rx_data;
  logic       rx_done;

  uart_rx_engine #(
    .DIV (DIV)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .rxd   (uart_rxd),
    .data  (rx_data),
    .done  (rx_done)
  );

  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, rx_irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_irq_en  <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (con_write) begin
        rx_irq_en <= MemBus_Write_Data[CON_RX_IRQ_EN];
        if (MemBus_Write_Data[CON_RX_OVERRUN]) rx_overrun <= 1'b0;
      end
      // A completing byte beats a same-cycle RXD read
      if (rx_done) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid && !rxd_read) rx_overrun <= 1'b1;
      end else if (rxd_read) begin
        rx_valid <= 1'b0;
      end
      irq <= rx_irq_en && rx_valid;
    end
  end

  always_comb begin
    Device_Read_Data = '0;
    if (sel_rxd) begin
      Device_Read_Data[7:0] = rx_byte;
    end else if (sel_con) begin
      Device_Read_Data[CON_RX_VALID]   = rx_valid;
      Device_Read_Data[CON_TX_FULL]    = fifo_full;
      Device_Read_Data[CON_TX_BUSY]    = tx_busy;
      Device_Read_Data[CON_RX_OVERRUN] = rx_overrun;
      Device_Read_Data[CON_RX_IRQ_EN]  = rx_irq_en;
    end
  end

endmodule

`default_nettype wire
